// File: rtl/pipe_ctrl.sv
`timescale 1ns/1ps
// pipe_ctrl: stall vector, jump/trap redirect and data-bus watchdog for the five-stage core.
// Latency: jump 0 cycles, trap >=1 cycle; backpressure: redirects wait out exe/mem stalls.
module pipe_ctrl #(
   parameter int ADDR_WIDTH  = 32,
   parameter int BUS_TIMEOUT = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  stallreq_if_i,
   input  logic                  stallreq_id_i,
   input  logic                  stallreq_exe_i,
   input  logic                  stallreq_mem_i,
   input  logic                  jump_req_i,
   input  logic [ADDR_WIDTH-1:0] jump_addr_i,
   input  logic                  trap_req_i,
   input  logic [ADDR_WIDTH-1:0] trap_addr_i,
   output logic [5:0]            stall_o,
   output logic                  flush_jump_o,
   output logic                  jump_o,
   output logic [ADDR_WIDTH-1:0] jump_addr_o,
   output logic                  trap_ack_o,
   output logic                  timeout_o
);

   typedef enum logic {RUN, TRAP_PEND} state_t;

   localparam bit          WD_EN   = (BUS_TIMEOUT != 0);
   localparam logic [15:0] WD_LAST = WD_EN ? 16'(BUS_TIMEOUT - 1) : 16'd0;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] trap_addr_q;
   logic [15:0]           wd_cnt;

   logic       busy;
   logic       jump_go;
   logic       trap_go;
   logic       wd_hit;
   logic [5:0] stall_enc;

   assign busy    = stallreq_mem_i | stallreq_exe_i;
   assign jump_go = jump_req_i && (state_q == RUN) && !busy;
   assign trap_go = (state_q == TRAP_PEND) && !busy;
   assign wd_hit  = WD_EN && stallreq_mem_i && (wd_cnt == WD_LAST);

   // Each pattern freezes the requesting stage and bubbles the next register down.
   always_comb begin
      stall_enc = 6'b000000;
      if (stallreq_mem_i)      stall_enc = 6'b011111;
      else if (stallreq_exe_i) stall_enc = 6'b001111;
      else if (stallreq_id_i)  stall_enc = 6'b000111;
      else if (stallreq_if_i)  stall_enc = 6'b000011;
   end

   always_comb begin
      stall_o      = 6'b000000;
      flush_jump_o = 1'b0;
      jump_o       = 1'b0;
      jump_addr_o  = '0;
      trap_ack_o   = 1'b0;
      timeout_o    = 1'b0;
      if (rst_n_i) begin
         timeout_o = wd_hit;
         if (trap_go) begin
            flush_jump_o = 1'b1;
            jump_o       = 1'b1;
            jump_addr_o  = trap_addr_q;
            trap_ack_o   = 1'b1;
         end else if (jump_go) begin
            flush_jump_o = 1'b1;
            jump_o       = 1'b1;
            jump_addr_o  = jump_addr_i;
         end else begin
            stall_o = stall_enc;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= RUN;
         trap_addr_q <= '0;
      end else begin
         case (state_q)
            RUN: begin
               if (trap_req_i) begin
                  trap_addr_q <= trap_addr_i;
                  state_q     <= TRAP_PEND;
               end
            end
            TRAP_PEND: begin
               // Further trap requests are dropped until the pending one is acknowledged.
               if (trap_go) state_q <= RUN;
            end
            default: state_q <= RUN;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wd_cnt <= 16'd0;
      end else if (!WD_EN || !stallreq_mem_i || wd_hit) begin
         wd_cnt <= 16'd0;
      end else begin
         wd_cnt <= wd_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
`timescale 1ns/1ps
// Directed-vector bench for pipe_ctrl with a queue-based scoreboard (BUS_TIMEOUT = 4).
module tb_pipe_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sr_if = 1'b0, sr_id = 1'b0, sr_exe = 1'b0, sr_mem = 1'b0;
   logic        jump_req = 1'b0;
   logic [31:0] jump_addr = '0;
   logic        trap_req = 1'b0;
   logic [31:0] trap_addr = '0;
   logic [5:0]  stall;
   logic        flush_jump, jump, trap_ack, timeout;
   logic [31:0] jump_addr_out;

   typedef struct {
      logic [5:0]  stall;
      logic        redir;
      logic [31:0] addr;
      logic        ack;
      logic        to;
      string       name;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   pipe_ctrl #(.ADDR_WIDTH(32), .BUS_TIMEOUT(4)) dut (
      .clk_i          (clk),
      .rst_n_i        (rst_n),
      .stallreq_if_i  (sr_if),
      .stallreq_id_i  (sr_id),
      .stallreq_exe_i (sr_exe),
      .stallreq_mem_i (sr_mem),
      .jump_req_i     (jump_req),
      .jump_addr_i    (jump_addr),
      .trap_req_i     (trap_req),
      .trap_addr_i    (trap_addr),
      .stall_o        (stall),
      .flush_jump_o   (flush_jump),
      .jump_o         (jump),
      .jump_addr_o    (jump_addr_out),
      .trap_ack_o     (trap_ack),
      .timeout_o      (timeout)
   );

   always #5 clk = ~clk;

   // req = {mem, exe, id, if}; expected redir covers both flush_jump_o and jump_o.
   task automatic apply(input logic rst, input logic [3:0] req,
                        input logic jr, input logic [31:0] ja,
                        input logic tr, input logic [31:0] ta,
                        input logic [5:0] e_stall, input logic e_redir,
                        input logic [31:0] e_addr, input logic e_ack,
                        input logic e_to, input string name);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n     = rst;
      sr_mem    = req[3];
      sr_exe    = req[2];
      sr_id     = req[1];
      sr_if     = req[0];
      jump_req  = jr;
      jump_addr = ja;
      trap_req  = tr;
      trap_addr = ta;
      e.stall = e_stall; e.redir = e_redir; e.addr = e_addr;
      e.ack = e_ack; e.to = e_to; e.name = name;
      q.push_back(e);
   endtask

   // Monitor: outputs are settled mid-cycle; compare against the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            exp_t e;
            bit   bad;
            e = q.pop_front();
            vectors++;
            bad = 1'b0;
            if (stall !== e.stall) begin
               $display("FAIL %s stall_o got %b want %b", e.name, stall, e.stall); bad = 1'b1;
            end
            if (flush_jump !== e.redir) begin
               $display("FAIL %s flush_jump_o got %b want %b", e.name, flush_jump, e.redir); bad = 1'b1;
            end
            if (jump !== e.redir) begin
               $display("FAIL %s jump_o got %b want %b", e.name, jump, e.redir); bad = 1'b1;
            end
            if (jump_addr_out !== e.addr) begin
               $display("FAIL %s jump_addr_o got %h want %h", e.name, jump_addr_out, e.addr); bad = 1'b1;
            end
            if (trap_ack !== e.ack) begin
               $display("FAIL %s trap_ack_o got %b want %b", e.name, trap_ack, e.ack); bad = 1'b1;
            end
            if (timeout !== e.to) begin
               $display("FAIL %s timeout_o got %b want %b", e.name, timeout, e.to); bad = 1'b1;
            end
            if (bad) miscompares++;
         end
      end
   end

   initial begin
      //     rst  req     jr ja            tr ta            stall      rd addr          ak to
      apply(0, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "reset");
      apply(0, 4'b1111, 1, 32'h1234,     1, 32'h5678,     6'b000000, 0, 32'h0,        0, 0, "reset_gate");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "idle");
      apply(1, 4'b0010, 0, 32'h0,        0, 32'h0,        6'b000111, 0, 32'h0,        0, 0, "stall_id");
      apply(1, 4'b0100, 0, 32'h0,        0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, "stall_exe");
      apply(1, 4'b1001, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 32'h0,        0, 0, "stall_mem_if");
      apply(1, 4'b0001, 0, 32'h0,        0, 32'h0,        6'b000011, 0, 32'h0,        0, 0, "stall_if");
      apply(1, 4'b0010, 1, 32'h80000040, 0, 32'h0,        6'b000000, 1, 32'h80000040, 0, 0, "jump_issue");
      apply(1, 4'b0100, 1, 32'h80000040, 0, 32'h0,        6'b001111, 0, 32'h0,        0, 0, "jump_blk_exe");
      apply(1, 4'b1000, 1, 32'h80000040, 0, 32'h0,        6'b011111, 0, 32'h0,        0, 0, "jump_blk_mem");
      apply(1, 4'b0000, 1, 32'h80000040, 0, 32'h0,        6'b000000, 1, 32'h80000040, 0, 0, "jump_release");
      // Trap raised during a 3-cycle memory stall.
      apply(1, 4'b1000, 0, 32'h0,        1, 32'h80000100, 6'b011111, 0, 32'h0,        0, 0, "trap_mem1");
      apply(1, 4'b1000, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 32'h0,        0, 0, "trap_mem2");
      apply(1, 4'b1000, 0, 32'h0,        0, 32'h0,        6'b011111, 0, 32'h0,        0, 0, "trap_mem3");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 32'h80000100, 1, 0, "trap_issue");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "trap_done");
      // Pending trap wins over a jump; a second trap request is dropped.
      apply(1, 4'b0100, 0, 32'h0,        1, 32'h80000300, 6'b001111, 0, 32'h0,        0, 0, "tbj_latch");
      apply(1, 4'b0100, 1, 32'h200,      1, 32'h00000999, 6'b001111, 0, 32'h0,        0, 0, "tbj_wait");
      apply(1, 4'b0010, 1, 32'h200,      0, 32'h0,        6'b000000, 1, 32'h80000300, 1, 0, "tbj_issue");
      apply(1, 4'b0000, 1, 32'h200,      0, 32'h0,        6'b000000, 1, 32'h200,      0, 0, "tbj_jump_after");
      // Simultaneous trap and qualifying jump in RUN.
      apply(1, 4'b0000, 1, 32'h400,      1, 32'h80000500, 6'b000000, 1, 32'h400,      0, 0, "sim_jump");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 1, 32'h80000500, 1, 0, "sim_trap");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "sim_idle");
      // Watchdog: 9-cycle memory stall pulses on cycles 4 and 8.
      for (int i = 1; i <= 9; i++)
         apply(1, 4'b1000, 0, 32'h0, 0, 32'h0, 6'b011111, 0, 32'h0, 0,
               (i == 4 || i == 8), $sformatf("wd9_c%0d", i));
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "wd9_end");
      for (int i = 1; i <= 3; i++)
         apply(1, 4'b1000, 0, 32'h0, 0, 32'h0, 6'b011111, 0, 32'h0, 0, 0, $sformatf("wd3_c%0d", i));
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "wd3_end");
      // Reset while a trap is pending: no ack after release.
      apply(1, 4'b1000, 0, 32'h0,        1, 32'h80000700, 6'b011111, 0, 32'h0,        0, 0, "rst_pend");
      apply(0, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "rst_assert");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "rst_release1");
      apply(1, 4'b0000, 0, 32'h0,        0, 32'h0,        6'b000000, 0, 32'h0,        0, 0, "rst_release2");

      for (int i = 0; i < 10 && q.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (q.size() != 0) begin
         $display("FAIL drain %0d expectations left, want 0", q.size());
         miscompares++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage RISC-V core. It turns per-stage stall requests, the execute-stage jump request and the CSR trap request into the `stall_o[5:0]` vector and flush/redirect signals. These outputs drive every pipeline register (if_id, id_exe, exe_mem, mem_wb) and the PC. It also queues trap entry until in-flight memory traffic completes, and flags a data-bus stall that never ends.

## Interface
- `ADDR_WIDTH`, default 32: width of redirect addresses; equals `` `ADDR_WIDTH ``.
- `BUS_TIMEOUT`, default 255: consecutive memory-stall cycles before `timeout_o` pulses. 0 disables the watchdog. Maximum 65535.
- `clk_i` in 1: core clock; all state is updated on its rising edge.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `stallreq_if_i` in 1: instruction fetch not ready.
- `stallreq_id_i` in 1: load-use hazard detected in decode.
- `stallreq_exe_i` in 1: multi-cycle execute operation is busy.
- `stallreq_mem_i` in 1: data bus wait.
- `jump_req_i` in 1: execute stage resolved a taken branch or jump.
- `jump_addr_i` in ADDR_WIDTH: target of the execute-stage jump.
- `trap_req_i` in 1: one-cycle pulse from csr requesting trap entry.
- `trap_addr_i` in ADDR_WIDTH: trap vector; valid while `trap_req_i` is high.
- `stall_o` out 6: per-stage stall vector. Bit0 = PC, bit1 = if_id, bit2 = id_exe, bit3 = exe_mem, bit4 = mem_wb, bit5 = wb. 1 = `` `STOP ``.
- `flush_jump_o` out 1: flush the wrong-path instructions in if_id and id_exe.
- `jump_o` out 1: load the PC from `jump_addr_o`.
- `jump_addr_o` out ADDR_WIDTH: redirect target.
- `trap_ack_o` out 1: one-cycle pulse in the cycle the trap redirect is issued.
- `timeout_o` out 1: one-cycle pulse when the bus watchdog expires.

## Operation
- **State.** The block has two states, RUN and TRAP_PEND. It also holds `trap_addr_q` (ADDR_WIDTH bits) and the watchdog counter `wd_cnt` (16 bits).
- **Stall encoding.** The stall vector uses a fixed priority: mem > exe > id > if.
  - mem → `6'b011111`
  - exe → `6'b001111`
  - id → `6'b000111`
  - if → `6'b000011`
  - none → `6'b000000`
  - The pattern places a bubble in the first register downstream of the frozen stage (stall[n]=1 with stall[n+1]=0).
- **Jump.** A jump is issued in the same cycle (combinational) when all of the following hold: `jump_req_i`=1, state RUN, `stallreq_mem_i`=0 and `stallreq_exe_i`=0. In that cycle:
  - `flush_jump_o`=1, `jump_o`=1, `jump_addr_o`=`jump_addr_i`.
  - The id and if stall requests are masked, so `stall_o`=0.
- **Jump blocked.** While an exe or mem stall is active, the jump is not issued. The execute stage holds its instruction, so `jump_req_i` persists until the stall clears.
- **Trap latch.** A `trap_req_i` pulse in RUN latches `trap_addr_i` into `trap_addr_q` and moves the state to TRAP_PEND.
- **Trap issue.** In TRAP_PEND, when `stallreq_mem_i`=0 and `stallreq_exe_i`=0, the block issues the trap redirect:
  - `flush_jump_o`=1, `jump_o`=1, `jump_addr_o`=`trap_addr_q`, `trap_ack_o`=1.
  - `stall_o`=0.
  - The state returns to RUN at the next edge.
- **Trap waiting.** Otherwise the block stays in TRAP_PEND and `stall_o` follows the normal encoding.
- **Jump during TRAP_PEND.** `jump_req_i` is ignored; the trap has precedence.
- **Trap request during TRAP_PEND.** A further `trap_req_i` is dropped. The first address is kept and the csr must not re-raise before `trap_ack_o`.
- **Simultaneous trap and jump in RUN.** `trap_req_i` and a qualifying `jump_req_i` in the same cycle: the jump issues that cycle and the trap latches. The trap issues at the earliest following cycle without an exe or mem stall.
- **Watchdog.**
  - `wd_cnt` increments each cycle that `stallreq_mem_i`=1 and clears to 0 in any cycle where it is 0.
  - When `wd_cnt` = `BUS_TIMEOUT`-1 and `stallreq_mem_i`=1, `timeout_o`=1 for that cycle and `wd_cnt` wraps to 0.
  - `timeout_o` does not alter `stall_o`.

## Timing
- **Reset.** While `rst_n_i`=0, every output is 0: `stall_o`=0, `flush_jump_o`=0, `jump_o`=0, `jump_addr_o`=0, `trap_ack_o`=0, `timeout_o`=0. Reset gates the combinational outputs too. State is RUN, `trap_addr_q`=0, `wd_cnt`=0.
- **Reset mid-operation.** Assertion drops any pending trap immediately, with no ack.
- **Reset release.** Deassertion is synchronized by the system. The first edge after release evaluates normally.
- **Combinational paths.** `stall_o`, `jump_o`, `flush_jump_o` and `jump_addr_o` are combinational from the request inputs and the state. Jump latency is 0 cycles.
- **Trap latency.** Minimum 1 cycle from `trap_req_i` to `trap_ack_o`. With a stall active, latency is 1 cycle plus the length of the exe/mem stall.
- **Pulse width.** `trap_ack_o` and `timeout_o` are single-cycle pulses. `flush_jump_o` lasts exactly one cycle per redirect.
- **Watchdog disabled.** With `BUS_TIMEOUT`=0, `timeout_o` is never asserted and `wd_cnt` stays 0.

## Test plan
- **Stall encoding:** assert `stallreq_id_i`, then `stallreq_exe_i`, then `stallreq_mem_i` together with `stallreq_if_i` → `stall_o` = `6'b000111`, then `6'b001111`, then `6'b011111`.
- **Jump issue:** `jump_req_i`=1 with `jump_addr_i`=0x80000040 and `stallreq_id_i`=1 → same cycle `flush_jump_o`=1, `jump_o`=1, `jump_addr_o`=0x80000040, `stall_o`=0.
- **Trap waits for memory:** `trap_req_i` pulse with `trap_addr_i`=0x80000100 while `stallreq_mem_i`=1 for 3 cycles → no redirect during the stall. In the first cycle with mem=0: `trap_ack_o`=1 and `jump_addr_o`=0x80000100, then RUN.
- **Trap beats jump:** in TRAP_PEND, `jump_req_i`=1 with `jump_addr_i`=0x200 → the redirect goes to the trap address; `jump_addr_o` is never 0x200 while pending.
- **Watchdog:** `BUS_TIMEOUT`=4, `stallreq_mem_i` held for 9 cycles → `timeout_o` pulses in cycles 4 and 8 only. A 3-cycle stall → no pulse.
- **Reset during pending trap:** `rst_n_i` asserted in TRAP_PEND → all outputs 0 at once. After release, no `trap_ack_o` appears.
